// File: rtl/os_scheduler_if.sv
// Handshake/bus bundle between the training controller (master) and the
// ordered-set scheduler (slave).
interface os_scheduler_if #(
    parameter int TS_CNT_W = 8
);
    logic                start;
    logic                stop;
    logic [TS_CNT_W-1:0] ts1_target;
    logic [TS_CNT_W-1:0] ts2_target;
    logic [7:0]          link_num;
    logic [7:0]          lane_num;
    logic [7:0]          n_fts;
    logic [7:0]          rate_id;
    logic [7:0]          train_ctl;
    logic [5:0]          ost;
    logic                en_n;
    logic [39:0]         ts_sym;
    logic                os_done;
    logic                link_up;
    logic [1:0]          state;

    modport master (
        output start, stop, ts1_target, ts2_target,
        output link_num, lane_num, n_fts, rate_id, train_ctl,
        input  ost, en_n, ts_sym, os_done, link_up, state
    );

    modport slave (
        input  start, stop, ts1_target, ts2_target,
        input  link_num, lane_num, n_fts, rate_id, train_ctl,
        output ost, en_n, ts_sym, os_done, link_up, state
    );
endinterface

// File: rtl/os_scheduler.sv
// Link-training ordered-set scheduler: TS1 x N, TS2 x M, then idle symbols,
// with periodic SKP sets inserted only on ordered-set boundaries.
module os_scheduler #(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_W        = 11,
    parameter int TS_CNT_W     = 8
) (
    input  logic           clk,
    input  logic           reset,
    os_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TS1    = 2'd1,
        S_TS2    = 2'd2,
        S_LINKUP = 2'd3
    } state_e;

    localparam logic [5:0]       OST_IDLE = 6'd0;
    localparam logic [5:0]       OST_SKP  = 6'd1;
    localparam logic [5:0]       OST_TS1  = 6'd2;
    localparam logic [5:0]       OST_TS2  = 6'd3;
    localparam logic [SKP_W-1:0] SKP_LAST = SKP_W'(SKP_INTERVAL - 1);

    state_e              state_q, state_d;
    logic [5:0]          ost_q, ost_d;
    logic                en_n_q, en_n_d;
    logic                os_done_q, os_done_d;
    logic                link_up_q, link_up_d;
    logic [39:0]         ts_sym_q, ts_sym_d;
    logic [3:0]          sym_ctr_q, sym_ctr_d;
    logic [TS_CNT_W-1:0] ts1_cnt_q, ts1_cnt_d, ts2_cnt_q, ts2_cnt_d;
    logic [TS_CNT_W-1:0] ts1_tgt_q, ts1_tgt_d, ts2_tgt_q, ts2_tgt_d;
    logic [SKP_W-1:0]    skp_ctr_q, skp_ctr_d;
    logic                skp_pending_q, skp_pending_d;

    logic                boundary, skp_wrap;
    logic [TS_CNT_W-1:0] cnt1_n, cnt2_n;

    function automatic logic [3:0] last_sym(input logic [5:0] o);
        case (o)
            OST_SKP:          return 4'd3;
            OST_TS1, OST_TS2: return 4'd15;
            default:          return 4'd0;
        endcase
    endfunction

    // Skips any phase whose target is already met, so zero targets fall through.
    function automatic state_e advance(input state_e s,
                                       input logic [TS_CNT_W-1:0] c1, t1,
                                       input logic [TS_CNT_W-1:0] c2, t2);
        state_e n;
        n = s;
        if (n == S_TS1 && c1 == t1) n = S_TS2;
        if (n == S_TS2 && c2 == t2) n = S_LINKUP;
        return n;
    endfunction

    function automatic logic [5:0] ost_of(input state_e s);
        case (s)
            S_TS1:   return OST_TS1;
            S_TS2:   return OST_TS2;
            default: return OST_IDLE;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        ost_d         = ost_q;
        en_n_d        = en_n_q;
        sym_ctr_d     = sym_ctr_q;
        ts1_cnt_d     = ts1_cnt_q;
        ts2_cnt_d     = ts2_cnt_q;
        ts1_tgt_d     = ts1_tgt_q;
        ts2_tgt_d     = ts2_tgt_q;
        skp_ctr_d     = skp_ctr_q;
        skp_pending_d = skp_pending_q;
        ts_sym_d      = {bus.train_ctl, bus.rate_id, bus.n_fts, bus.lane_num, bus.link_num};

        boundary = !en_n_q && (sym_ctr_q == last_sym(ost_q));
        skp_wrap = !en_n_q && (skp_ctr_q == SKP_LAST);

        // TS totals count completed sets only; SKP boundaries leave them alone.
        cnt1_n = ts1_cnt_q;
        cnt2_n = ts2_cnt_q;
        if (boundary && ost_q == OST_TS1) cnt1_n = ts1_cnt_q + TS_CNT_W'(1);
        if (boundary && ost_q == OST_TS2) cnt2_n = ts2_cnt_q + TS_CNT_W'(1);

        if (!en_n_q) skp_ctr_d = skp_wrap ? '0 : skp_ctr_q + SKP_W'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    ts1_tgt_d = bus.ts1_target;
                    ts2_tgt_d = bus.ts2_target;
                    ts1_cnt_d = '0;
                    ts2_cnt_d = '0;
                    skp_ctr_d = '0;
                    sym_ctr_d = '0;
                    en_n_d    = 1'b0;
                    state_d   = advance(S_TS1, '0, bus.ts1_target, '0, bus.ts2_target);
                    ost_d     = ost_of(state_d);
                end
            end
            default: begin
                if (boundary) begin
                    sym_ctr_d = '0;
                    ts1_cnt_d = cnt1_n;
                    ts2_cnt_d = cnt2_n;
                    if (bus.stop) begin
                        state_d       = S_IDLE;
                        en_n_d        = 1'b1;
                        ost_d         = OST_IDLE;
                        skp_pending_d = 1'b0;
                    end else if (skp_pending_q || skp_wrap) begin
                        ost_d         = OST_SKP;
                        skp_pending_d = 1'b0;
                    end else begin
                        state_d = advance(state_q, cnt1_n, ts1_tgt_q, cnt2_n, ts2_tgt_q);
                        ost_d   = ost_of(state_d);
                    end
                end else begin
                    sym_ctr_d = sym_ctr_q + 4'd1;
                    if (skp_wrap) skp_pending_d = 1'b1;
                end
            end
        endcase

        // os_done is registered, so it is derived from the cycle about to start.
        os_done_d = !en_n_d && (sym_ctr_d == last_sym(ost_d));
        link_up_d = (state_d == S_LINKUP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ost_q         <= OST_IDLE;
            en_n_q        <= 1'b1;
            os_done_q     <= 1'b0;
            link_up_q     <= 1'b0;
            ts_sym_q      <= '0;
            sym_ctr_q     <= '0;
            ts1_cnt_q     <= '0;
            ts2_cnt_q     <= '0;
            ts1_tgt_q     <= '0;
            ts2_tgt_q     <= '0;
            skp_ctr_q     <= '0;
            skp_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ost_q         <= ost_d;
            en_n_q        <= en_n_d;
            os_done_q     <= os_done_d;
            link_up_q     <= link_up_d;
            ts_sym_q      <= ts_sym_d;
            sym_ctr_q     <= sym_ctr_d;
            ts1_cnt_q     <= ts1_cnt_d;
            ts2_cnt_q     <= ts2_cnt_d;
            ts1_tgt_q     <= ts1_tgt_d;
            ts2_tgt_q     <= ts2_tgt_d;
            skp_ctr_q     <= skp_ctr_d;
            skp_pending_q <= skp_pending_d;
        end
    end

    assign bus.ost     = ost_q;
    assign bus.en_n    = en_n_q;
    assign bus.ts_sym  = ts_sym_q;
    assign bus.os_done = os_done_q;
    assign bus.link_up = link_up_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_os_scheduler.sv
// Bench for os_scheduler: three instances (SKP interval 1180, 20, 16) share one
// stimulus stream; a set-level model is checked every cycle, plus literal pins.
module tb_os_scheduler;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop;
    logic [7:0] ts1_t, ts2_t, ln, la, nf, ri, tc;

    always #5 clk = ~clk;

    os_scheduler_if #(.TS_CNT_W(8)) bus0 ();
    os_scheduler_if #(.TS_CNT_W(8)) bus1 ();
    os_scheduler_if #(.TS_CNT_W(8)) bus2 ();

    assign bus0.start = start; assign bus0.stop = stop;
    assign bus0.ts1_target = ts1_t; assign bus0.ts2_target = ts2_t;
    assign bus0.link_num = ln; assign bus0.lane_num = la; assign bus0.n_fts = nf;
    assign bus0.rate_id = ri; assign bus0.train_ctl = tc;
    assign bus1.start = start; assign bus1.stop = stop;
    assign bus1.ts1_target = ts1_t; assign bus1.ts2_target = ts2_t;
    assign bus1.link_num = ln; assign bus1.lane_num = la; assign bus1.n_fts = nf;
    assign bus1.rate_id = ri; assign bus1.train_ctl = tc;
    assign bus2.start = start; assign bus2.stop = stop;
    assign bus2.ts1_target = ts1_t; assign bus2.ts2_target = ts2_t;
    assign bus2.link_num = ln; assign bus2.lane_num = la; assign bus2.n_fts = nf;
    assign bus2.rate_id = ri; assign bus2.train_ctl = tc;

    os_scheduler #(.SKP_INTERVAL(1180), .SKP_W(11), .TS_CNT_W(8)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    os_scheduler #(.SKP_INTERVAL(20),   .SKP_W(11), .TS_CNT_W(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    os_scheduler #(.SKP_INTERVAL(16),   .SKP_W(11), .TS_CNT_W(8)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    logic [5:0]  d_ost [N];
    logic        d_en_n[N], d_done[N], d_lu[N];
    logic [1:0]  d_st  [N];
    logic [39:0] d_sym [N];
    assign d_ost[0] = bus0.ost; assign d_en_n[0] = bus0.en_n; assign d_done[0] = bus0.os_done;
    assign d_lu[0] = bus0.link_up; assign d_st[0] = bus0.state; assign d_sym[0] = bus0.ts_sym;
    assign d_ost[1] = bus1.ost; assign d_en_n[1] = bus1.en_n; assign d_done[1] = bus1.os_done;
    assign d_lu[1] = bus1.link_up; assign d_st[1] = bus1.state; assign d_sym[1] = bus1.ts_sym;
    assign d_ost[2] = bus2.ost; assign d_en_n[2] = bus2.en_n; assign d_done[2] = bus2.os_done;
    assign d_lu[2] = bus2.link_up; assign d_st[2] = bus2.state; assign d_sym[2] = bus2.ts_sym;

    int n_chk = 0, n_pass = 0, cyc = 0;
    logic chk_en = 1'b0;

    // Model: the current set is described by its kind (ost code) and symbols left;
    // the SKP timer is simply active cycles since entry modulo the interval.
    int          m_act[N], m_st[N], m_kind[N], m_left[N], m_timer[N], m_pend[N];
    int          m_d1[N], m_d2[N], m_t1[N], m_t2[N];
    logic [39:0] m_sym[N];

    function automatic int interval(input int i);
        return (i == 0) ? 1180 : (i == 1) ? 20 : 16;
    endfunction

    function automatic int set_len(input int kind);
        return (kind == 0) ? 1 : (kind == 1) ? 4 : 16;
    endfunction

    task automatic follow(input int i);
        if (m_st[i] == 1 && m_d1[i] >= m_t1[i]) m_st[i] = 2;
        if (m_st[i] == 2 && m_d2[i] >= m_t2[i]) m_st[i] = 3;
        m_kind[i] = (m_st[i] == 1) ? 2 : (m_st[i] == 2) ? 3 : 0;
        m_left[i] = set_len(m_kind[i]);
    endtask

    task automatic mstep(input int i);
        bit wrap;
        if (reset) begin
            m_act[i] = 0; m_st[i] = 0; m_kind[i] = 0; m_left[i] = 1; m_timer[i] = 0;
            m_pend[i] = 0; m_d1[i] = 0; m_d2[i] = 0; m_t1[i] = 0; m_t2[i] = 0; m_sym[i] = '0;
            return;
        end
        m_sym[i] = {tc, ri, nf, la, ln};
        if (m_act[i] == 0) begin
            if (start && !stop) begin
                m_t1[i] = int'(ts1_t); m_t2[i] = int'(ts2_t);
                m_d1[i] = 0; m_d2[i] = 0; m_timer[i] = 0;
                m_act[i] = 1; m_st[i] = 1;
                follow(i);
            end
        end else begin
            wrap = (m_timer[i] % interval(i)) == interval(i) - 1;
            m_timer[i]++;
            if (m_left[i] == 1) begin
                if (m_kind[i] == 2) m_d1[i]++;
                if (m_kind[i] == 3) m_d2[i]++;
                if (stop) begin
                    m_act[i] = 0; m_st[i] = 0; m_kind[i] = 0; m_left[i] = 1; m_pend[i] = 0;
                end else if (m_pend[i] != 0 || wrap) begin
                    m_kind[i] = 1; m_left[i] = 4; m_pend[i] = 0;
                end else begin
                    follow(i);
                end
            end else begin
                if (wrap) m_pend[i] = 1;
                m_left[i]--;
            end
        end
    endtask

    always @(posedge clk) for (int i = 0; i < N; i++) mstep(i);

    task automatic chk(input string nm, input int id, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, id, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                chk("ost",     i, 40'(d_ost[i]),  40'(m_kind[i]));
                chk("en_n",    i, 40'(d_en_n[i]), 40'(m_act[i] == 0));
                chk("os_done", i, 40'(d_done[i]), 40'(m_act[i] != 0 && m_left[i] == 1));
                chk("link_up", i, 40'(d_lu[i]),   40'(m_st[i] == 3));
                chk("state",   i, 40'(d_st[i]),   40'(m_st[i]));
                chk("ts_sym",  i, d_sym[i],       m_sym[i]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic go_to(input int k);
        while (cyc < k) tick();
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after the start edge.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; ts1_t = '0; ts2_t = '0;
        ln = 8'h5A; la = 8'hC3; nf = 8'h77; ri = 8'h01; tc = 8'hFF;
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ost",    0, 40'(bus0.ost), 40'd0);
        chk("rst_en_n",   0, 40'(bus0.en_n), 40'd1);
        chk("rst_state",  0, 40'(bus0.state), 40'd0);
        chk("rst_ts_sym", 0, bus0.ts_sym, 40'd0);
        reset = 1'b0;
        @(negedge clk);

        // Normal training, TS1 x2 then TS2 x1
        ts1_t = 8'd2; ts2_t = 8'd1;
        ln = 8'hA1; la = 8'h02; nf = 8'h1F; ri = 8'h06; tc = 8'h00;
        do_start();
        chk("n_c1_ost",    0, 40'(bus0.ost), 40'd2);
        chk("n_c1_state",  0, 40'(bus0.state), 40'd1);
        chk("n_c1_ts_sym", 0, bus0.ts_sym, 40'h00_06_1F_02_A1);
        go_to(16); chk("n_c16_done", 0, 40'(bus0.os_done), 40'd1);
        go_to(17); chk("n_c17_done", 0, 40'(bus0.os_done), 40'd0);
        go_to(32); chk("n_c32_done", 0, 40'(bus0.os_done), 40'd1);
        go_to(33); chk("n_c33_ost",  0, 40'(bus0.ost), 40'd3);
        go_to(48); chk("n_c48_done", 0, 40'(bus0.os_done), 40'd1);
        go_to(49); chk("n_c49_ost",  0, 40'(bus0.ost), 40'd0);
                   chk("n_c49_lu",   0, 40'(bus0.link_up), 40'd1);
        go_to(55);
        apply_reset();

        // Reset in the middle of TS2 (sym_ctr=7 on cycle 24)
        ts1_t = 8'd1; ts2_t = 8'd1;
        do_start();
        go_to(24); chk("r_c24_ost", 0, 40'(bus0.ost), 40'd3);
        reset = 1'b1;
        tick();
        chk("r_ost",  0, 40'(bus0.ost), 40'd0);
        chk("r_en_n", 0, 40'(bus0.en_n), 40'd1);
        chk("r_st",   0, 40'(bus0.state), 40'd0);
        chk("r_done", 0, 40'(bus0.os_done), 40'd0);
        tick();
        reset = 1'b0;
        tick();

        // SKP insertion with interval 20, TS1 x3, no TS2
        ts1_t = 8'd3; ts2_t = 8'd0;
        ln = 8'h33; la = 8'h44; nf = 8'h55; ri = 8'h66; tc = 8'h77;
        do_start();
        go_to(32); chk("s_c32_done", 1, 40'(bus1.os_done), 40'd1);
        go_to(33); chk("s_c33_ost",  1, 40'(bus1.ost), 40'd1);
        go_to(36); chk("s_c36_ost",  1, 40'(bus1.ost), 40'd1);
        go_to(37); chk("s_c37_ost",  1, 40'(bus1.ost), 40'd2);
        go_to(52); chk("s_c52_lu",   1, 40'(bus1.link_up), 40'd0);
        go_to(53); chk("s_c53_ost",  1, 40'(bus1.ost), 40'd1);
        go_to(57); chk("s_c57_lu",   1, 40'(bus1.link_up), 40'd1);
        go_to(62);
        apply_reset();

        // Zero targets: straight to LINKUP, SKP after the first wrap
        ts1_t = 8'd0; ts2_t = 8'd0;
        do_start();
        chk("z_c1_state", 1, 40'(bus1.state), 40'd3);
        chk("z_c1_en_n",  1, 40'(bus1.en_n), 40'd0);
        go_to(20); chk("z_c20_ost", 1, 40'(bus1.ost), 40'd0);
        go_to(21); chk("z_c21_ost", 1, 40'(bus1.ost), 40'd1);
        go_to(24); chk("z_c24_ost", 1, 40'(bus1.ost), 40'd1);
        go_to(25); chk("z_c25_ost", 1, 40'(bus1.ost), 40'd0);
        go_to(30);
        stop = 1'b1;
        tick(); chk("z_stop_st", 1, 40'(bus1.state), 40'd0);
        start = 1'b1; tick(); start = 1'b0; tick();
        chk("z_stop_start_st", 0, 40'(bus0.state), 40'd0);
        stop = 1'b0;
        tick();

        // Stop raised mid-TS1; interval-16 instance also wraps on that boundary
        ts1_t = 8'd4; ts2_t = 8'd1;
        do_start();
        go_to(6);  stop = 1'b1;
        go_to(10); start = 1'b1; tick(); start = 1'b0;
        go_to(16);
        chk("p_c16_done", 0, 40'(bus0.os_done), 40'd1);
        chk("p_c16_ost",  0, 40'(bus0.ost), 40'd2);
        chk("p_c16_done", 2, 40'(bus2.os_done), 40'd1);
        go_to(17);
        chk("p_c17_en_n", 0, 40'(bus0.en_n), 40'd1);
        chk("p_c17_st",   0, 40'(bus0.state), 40'd0);
        chk("p_c17_ost",  2, 40'(bus2.ost), 40'd0);
        stop = 1'b0;
        go_to(25); chk("p_c25_st", 0, 40'(bus0.state), 40'd0);

        // Restart: no stale SKP request may survive the stop
        ts1_t = 8'd0; ts2_t = 8'd0;
        do_start();
        go_to(2);  chk("q_c2_ost",  2, 40'(bus2.ost), 40'd0);
        go_to(17); chk("q_c17_ost", 2, 40'(bus2.ost), 40'd1);
        go_to(25);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
